// File: rtl/gpu_bg_pixel_writer.sv
// gpu_bg_pixel_writer
// Executes the gwbg micro-op: latches a tile row (BH/BL) and the BG palette,
// then writes 8 palette-mapped 2-bit shades into the framebuffer, MSB pixel
// first, one shade per accepted write (oFbWe && iFbReady).
//
// Ports:
//   iClock, iReset      clock, asynchronous active-low reset
//   iStart              one-cycle gwbg strobe (honoured in IDLE only)
//   iBh, iBl, iBgp      tile row high/low bytes and BG palette
//   iAddrLoad/iAddrValue load the framebuffer address counter (IDLE only)
//   iFbReady            framebuffer accepts a write this cycle
//   oFbWe/oFbAddr/oFbData framebuffer write request, address, shade
//   oBusy               gwbg in progress
//   oDone               one-cycle pulse after the final pixel write
//   oWrap               one-cycle pulse when the address wraps FB_LAST -> 0
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for iStart; address counter may be loaded
// SHIFT  | presenting one pixel per cycle, advancing on each accepted write
module gpu_bg_pixel_writer #(
    parameter int FB_ADDR_W  = 13,
    parameter int FB_LAST    = 8191,
    parameter int PIX_PER_OP = 8
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic [7:0]           iBh,
    input  logic [7:0]           iBl,
    input  logic [7:0]           iBgp,
    input  logic                 iAddrLoad,
    input  logic [FB_ADDR_W-1:0] iAddrValue,
    input  logic                 iFbReady,
    output logic                 oFbWe,
    output logic [FB_ADDR_W-1:0] oFbAddr,
    output logic [1:0]           oFbData,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oWrap
);

    localparam int CNT_W = $clog2(PIX_PER_OP + 1);
    localparam logic [FB_ADDR_W-1:0] ADDR_LAST = FB_ADDR_W'(FB_LAST);
    // One bit wider so the clamp compare stays meaningful even when FB_LAST
    // is the largest value the address width can hold.
    localparam logic [FB_ADDR_W:0]   LAST_EXT  = (FB_ADDR_W + 1)'(FB_LAST);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(PIX_PER_OP - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             bh_q, bh_d;
    logic [7:0]             bl_q, bl_d;
    logic [7:0]             bgp_q, bgp_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FB_ADDR_W-1:0]   addr_q, addr_d;
    logic                   done_q, done_d;
    logic                   wrap_q, wrap_d;

    logic                   busy;
    logic [1:0]             pix_idx;
    logic [FB_ADDR_W-1:0]   load_val;

    assign busy     = (state_q == ST_SHIFT);
    assign pix_idx  = {bh_q[7], bl_q[7]};
    assign load_val = ({1'b0, iAddrValue} > LAST_EXT) ? ADDR_LAST : iAddrValue;

    assign oBusy   = busy;
    assign oFbWe   = busy;
    assign oFbAddr = addr_q;
    // Palette lookup straight off the shift-register MSBs; forced to 0 while
    // idle so stale tile data never reaches the bus.
    assign oFbData = busy ? bgp_q[{pix_idx, 1'b0} +: 2] : 2'b00;
    assign oDone   = done_q;
    assign oWrap   = wrap_q;

    always_comb begin
        state_d = state_q;
        bh_d    = bh_q;
        bl_d    = bl_q;
        bgp_d   = bgp_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iAddrLoad) begin
                    addr_d = load_val;
                end
                if (iStart) begin
                    bh_d    = iBh;
                    bl_d    = iBl;
                    bgp_d   = iBgp;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // iFbReady low simply holds everything: a stall.
                if (iFbReady) begin
                    bh_d  = {bh_q[6:0], 1'b0};
                    bl_d  = {bl_q[6:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (addr_q == ADDR_LAST) begin
                        addr_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        addr_d = addr_q + FB_ADDR_W'(1);
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= ST_IDLE;
            bh_q    <= '0;
            bl_q    <= '0;
            bgp_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bh_q    <= bh_d;
            bl_q    <= bl_d;
            bgp_q   <= bgp_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule

// File: tb/tb_gpu_bg_pixel_writer.sv
// Testbench for gpu_bg_pixel_writer: randomised bursts compared against a
// row/palette reference model computed from the pixel-mapping rules.
module tb_gpu_bg_pixel_writer;

    localparam int AW   = 13;
    localparam int LAST = 8191;

    logic          iClock = 1'b0;
    logic          iReset = 1'b0;
    logic          iStart = 1'b0;
    logic [7:0]    iBh = '0, iBl = '0, iBgp = '0;
    logic          iAddrLoad = 1'b0;
    logic [AW-1:0] iAddrValue = '0;
    logic          iFbReady = 1'b0;
    logic          oFbWe;
    logic [AW-1:0] oFbAddr;
    logic [1:0]    oFbData;
    logic          oBusy, oDone, oWrap;

    gpu_bg_pixel_writer #(.FB_ADDR_W(AW), .FB_LAST(LAST), .PIX_PER_OP(8)) dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iStart    (iStart),
        .iBh       (iBh),
        .iBl       (iBl),
        .iBgp      (iBgp),
        .iAddrLoad (iAddrLoad),
        .iAddrValue(iAddrValue),
        .iFbReady  (iFbReady),
        .oFbWe     (oFbWe),
        .oFbAddr   (oFbAddr),
        .oFbData   (oFbData),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oWrap     (oWrap)
    );

    always #5 iClock = ~iClock;

    int checks = 0;
    int errors = 0;

    // Observations of one burst, cycles counted from the iStart cycle (= 0).
    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    int wrap_cyc[$];
    int busy_cycles;
    int done_cycle;
    bit timed_out;

    // Reference model: shade of pixel k from the row bytes and palette.
    function automatic int exp_pix(input int bh, input int bl, input int bgp, input int k);
        int idx;
        idx = 2 * ((bh >> (7 - k)) % 2) + ((bl >> (7 - k)) % 2);
        return (bgp / (4 ** idx)) % 4;
    endfunction

    function automatic int exp_addr(input int base, input int k);
        return (base + k) % (LAST + 1);
    endfunction

    // Drives one burst and records what the framebuffer side sees.
    // mode: 0 ready always, 1 ready low on odd cycles, 2 random ready.
    // mid_start: cycle at which a second iStart (with an iAddrLoad) is pulsed.
    // stop_after: >0 returns right after that many accepted writes.
    task automatic run_burst(input logic [7:0] bh, input logic [7:0] bl, input logic [7:0] bgp,
                             input bit do_load, input logic [AW-1:0] lval,
                             input int mode, input int mid_start, input int stop_after);
        bit stopped;
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); wrap_cyc.delete();
        busy_cycles = 0;
        done_cycle  = -1;
        timed_out   = 1'b0;
        stopped     = 1'b0;
        for (int c = 0; c < 200; c++) begin
            iStart     = (c == 0) || (c == mid_start);
            iAddrLoad  = (c == 0 && do_load) || (c == mid_start);
            iAddrValue = (c == 0) ? lval : AW'(13'h1ABC);
            if (c == 0) begin
                iBh = bh; iBl = bl; iBgp = bgp;
            end else begin
                iBh = 8'($urandom); iBl = 8'($urandom); iBgp = 8'($urandom);
            end
            case (mode)
                0:       iFbReady = 1'b1;
                1:       iFbReady = (c % 2 == 0);
                default: iFbReady = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (oBusy) busy_cycles++;
            if (oFbWe && iFbReady) begin
                obs_addr.push_back(int'(oFbAddr));
                obs_data.push_back(int'(oFbData));
                obs_cyc.push_back(c);
            end
            if (oWrap) wrap_cyc.push_back(c);
            if (c > 0 && oDone) begin
                done_cycle = c;
                break;
            end
            @(posedge iClock); #1;
            if (stop_after > 0 && obs_addr.size() == stop_after) begin
                stopped = 1'b1;
                break;
            end
        end
        if (done_cycle < 0 && !stopped) timed_out = 1'b1;
        iStart    = 1'b0;
        iAddrLoad = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (oFbWe !== 1'b0)   begin errors++; $display("FAIL reset_we got %0b expected 0", oFbWe); end
        checks++; if (oBusy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %0b expected 0", oBusy); end
        checks++; if (oDone !== 1'b0)   begin errors++; $display("FAIL reset_done got %0b expected 0", oDone); end
        checks++; if (oWrap !== 1'b0)   begin errors++; $display("FAIL reset_wrap got %0b expected 0", oWrap); end
        checks++; if (oFbAddr !== '0)   begin errors++; $display("FAIL reset_addr got %0d expected 0", oFbAddr); end
        checks++; if (oFbData !== 2'b0) begin errors++; $display("FAIL reset_data got %0d expected 0", oFbData); end
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(posedge iClock); #1;
    endtask

    task automatic test_basic();
        run_burst(8'hFF, 8'h00, 8'hE4, 1'b1, AW'(13'h0100), 0, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got no oDone expected oDone"); end
        checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL basic_count got %0d expected 8", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 8; k++) begin
            checks++; if (obs_addr[k] !== 'h100 + k) begin errors++; $display("FAIL basic_addr%0d got %0h expected %0h", k, obs_addr[k], 'h100 + k); end
            checks++; if (obs_data[k] !== 2) begin errors++; $display("FAIL basic_data%0d got %0d expected 2", k, obs_data[k]); end
        end
        checks++; if (done_cycle !== 9) begin errors++; $display("FAIL basic_latency got %0d expected 9", done_cycle); end
        checks++; if (busy_cycles !== 8) begin errors++; $display("FAIL basic_busy got %0d expected 8", busy_cycles); end
        checks++; if (oFbAddr !== AW'(13'h108)) begin errors++; $display("FAIL basic_final_addr got %0h expected 108", oFbAddr); end
        checks++; if (wrap_cyc.size() != 0) begin errors++; $display("FAIL basic_wrap got %0d expected 0", wrap_cyc.size()); end
        @(posedge iClock); #1;
        checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL basic_done_width got %0b expected 0", oDone); end
    endtask

    task automatic test_patterns();
        int bgps[2];
        int base;
        bgps[0] = 'hE4; bgps[1] = 'h1B;
        for (int p = 0; p < 2; p++) begin
            base = int'(oFbAddr);
            run_burst(8'hA5, 8'h3C, 8'(bgps[p]), 1'b0, '0, 0, -1, 0);
            checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL pattern%0d_count got %0d expected 8", p, obs_addr.size()); end
            for (int k = 0; k < obs_addr.size() && k < 8; k++) begin
                checks++; if (obs_data[k] !== exp_pix('hA5, 'h3C, bgps[p], k)) begin errors++; $display("FAIL pattern%0d_data%0d got %0d expected %0d", p, k, obs_data[k], exp_pix('hA5, 'h3C, bgps[p], k)); end
                checks++; if (obs_addr[k] !== exp_addr(base, k)) begin errors++; $display("FAIL pattern%0d_addr%0d got %0h expected %0h", p, k, obs_addr[k], exp_addr(base, k)); end
            end
            checks++; if (done_cycle !== 9) begin errors++; $display("FAIL pattern%0d_latency got %0d expected 9", p, done_cycle); end
            @(posedge iClock); #1;
        end
    endtask

    task automatic test_stall();
        int base;
        base = int'(oFbAddr);
        run_burst(8'hA5, 8'h3C, 8'hE4, 1'b0, '0, 1, -1, 0);
        checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL stall_count got %0d expected 8", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 8; k++) begin
            checks++; if (obs_addr[k] !== exp_addr(base, k) || obs_data[k] !== exp_pix('hA5, 'h3C, 'hE4, k)) begin
                errors++; $display("FAIL stall_write%0d got %0h/%0d expected %0h/%0d", k, obs_addr[k], obs_data[k], exp_addr(base, k), exp_pix('hA5, 'h3C, 'hE4, k));
            end
        end
        checks++; if (busy_cycles !== 16) begin errors++; $display("FAIL stall_busy got %0d expected 16", busy_cycles); end
        if (obs_cyc.size() == 8) begin
            checks++; if (done_cycle !== obs_cyc[7] + 1) begin errors++; $display("FAIL stall_done got %0d expected %0d", done_cycle, obs_cyc[7] + 1); end
        end
        @(posedge iClock); #1;
    endtask

    task automatic test_wrap();
        run_burst(8'h0F, 8'h33, 8'h6C, 1'b1, AW'(8188), 0, -1, 0);
        checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL wrap_count got %0d expected 8", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 8; k++) begin
            checks++; if (obs_addr[k] !== exp_addr(8188, k)) begin errors++; $display("FAIL wrap_addr%0d got %0d expected %0d", k, obs_addr[k], exp_addr(8188, k)); end
        end
        checks++; if (wrap_cyc.size() != 1) begin errors++; $display("FAIL wrap_pulses got %0d expected 1", wrap_cyc.size()); end
        else if (obs_cyc.size() == 8) begin
            checks++; if (wrap_cyc[0] !== obs_cyc[3] + 1) begin errors++; $display("FAIL wrap_timing got %0d expected %0d", wrap_cyc[0], obs_cyc[3] + 1); end
        end
        checks++; if (oFbAddr !== AW'(4)) begin errors++; $display("FAIL wrap_final_addr got %0d expected 4", oFbAddr); end
        @(posedge iClock); #1;
    endtask

    task automatic test_reset_mid();
        run_burst(8'hC3, 8'h5A, 8'hE4, 1'b1, AW'(13'h0200), 0, -1, 3);
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %0b expected 1", oBusy); end
        iReset = 1'b0;
        #1;
        checks++; if ({oFbWe, oBusy, oDone, oWrap} !== 4'b0) begin errors++; $display("FAIL abort_flags got %b expected 0000", {oFbWe, oBusy, oDone, oWrap}); end
        checks++; if (oFbAddr !== '0 || oFbData !== 2'b0) begin errors++; $display("FAIL abort_bus got %0h/%0d expected 0/0", oFbAddr, oFbData); end
        @(posedge iClock); #1;
        iReset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge iClock); #1;
            checks++; if (oFbWe !== 1'b0 || oDone !== 1'b0) begin errors++; $display("FAIL abort_quiet%0d got we=%0b done=%0b expected 0/0", c, oFbWe, oDone); end
        end
        run_burst(8'h96, 8'hF0, 8'h1B, 1'b0, '0, 0, -1, 0);
        checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL abort_clean_count got %0d expected 8", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 8; k++) begin
            checks++; if (obs_addr[k] !== k || obs_data[k] !== exp_pix('h96, 'hF0, 'h1B, k)) begin
                errors++; $display("FAIL abort_clean%0d got %0h/%0d expected %0h/%0d", k, obs_addr[k], obs_data[k], k, exp_pix('h96, 'hF0, 'h1B, k));
            end
        end
        @(posedge iClock); #1;
    endtask

    task automatic test_load_and_restart();
        run_burst(8'h81, 8'h7E, 8'hD2, 1'b1, AW'(13'h0040), 0, 4, 0);
        checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL restart_count got %0d expected 8", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 8; k++) begin
            checks++; if (obs_addr[k] !== 'h40 + k || obs_data[k] !== exp_pix('h81, 'h7E, 'hD2, k)) begin
                errors++; $display("FAIL restart_write%0d got %0h/%0d expected %0h/%0d", k, obs_addr[k], obs_data[k], 'h40 + k, exp_pix('h81, 'h7E, 'hD2, k));
            end
        end
        checks++; if (done_cycle !== 9) begin errors++; $display("FAIL restart_latency got %0d expected 9", done_cycle); end
        @(posedge iClock); #1;
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL restart_idle got %0b expected 0", oBusy); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = int'(oFbAddr);
        run_burst(8'h3C, 8'hC3, 8'hE4, 1'b0, '0, 0, -1, 0);
        checks++; if (done_cycle !== 9) begin errors++; $display("FAIL b2b_first_latency got %0d expected 9", done_cycle); end
        // Next start issued in the oDone cycle.
        run_burst(8'h55, 8'hAA, 8'h39, 1'b0, '0, 0, -1, 0);
        checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL b2b_count got %0d expected 8", obs_addr.size()); end
        else begin
            checks++; if (obs_cyc[0] !== 1) begin errors++; $display("FAIL b2b_first_write_cycle got %0d expected 1", obs_cyc[0]); end
        end
        for (int k = 0; k < obs_addr.size() && k < 8; k++) begin
            checks++; if (obs_addr[k] !== exp_addr(base, 8 + k) || obs_data[k] !== exp_pix('h55, 'hAA, 'h39, k)) begin
                errors++; $display("FAIL b2b_write%0d got %0h/%0d expected %0h/%0d", k, obs_addr[k], obs_data[k], exp_addr(base, 8 + k), exp_pix('h55, 'hAA, 'h39, k));
            end
        end
        checks++; if (done_cycle !== 9) begin errors++; $display("FAIL b2b_second_latency got %0d expected 9", done_cycle); end
        @(posedge iClock); #1;
    endtask

    task automatic test_random();
        int base, bh, bl, bgp, nwrap;
        bit ld;
        for (int r = 0; r < 8; r++) begin
            bh  = int'($urandom_range(0, 255));
            bl  = int'($urandom_range(0, 255));
            bgp = int'($urandom_range(0, 255));
            ld  = 1'($urandom_range(0, 1));
            base = ld ? ((r % 2 == 0) ? int'($urandom_range(LAST - 9, LAST)) : int'($urandom_range(0, LAST)))
                      : int'(oFbAddr);
            run_burst(8'(bh), 8'(bl), 8'(bgp), ld, AW'(base), 2, -1, 0);
            checks++; if (timed_out || obs_addr.size() != 8) begin errors++; $display("FAIL rand%0d_count got %0d expected 8", r, obs_addr.size()); end
            for (int k = 0; k < obs_addr.size() && k < 8; k++) begin
                checks++; if (obs_addr[k] !== exp_addr(base, k) || obs_data[k] !== exp_pix(bh, bl, bgp, k)) begin
                    errors++; $display("FAIL rand%0d_write%0d got %0h/%0d expected %0h/%0d", r, k, obs_addr[k], obs_data[k], exp_addr(base, k), exp_pix(bh, bl, bgp, k));
                end
            end
            nwrap = 0;
            for (int k = 0; k < 8; k++) if (exp_addr(base, k) == LAST) nwrap++;
            checks++; if (wrap_cyc.size() != nwrap) begin errors++; $display("FAIL rand%0d_wrap got %0d expected %0d", r, wrap_cyc.size(), nwrap); end
            checks++; if (int'(oFbAddr) !== exp_addr(base, 8)) begin errors++; $display("FAIL rand%0d_final_addr got %0d expected %0d", r, oFbAddr, exp_addr(base, 8)); end
            @(posedge iClock); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_load_and_restart();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
